// File: rtl/btn_count_fsm.sv
// btn_count_fsm
//   Counts debounced presses of a single push-button and produces a one-cycle
//   pulse on every TARGET-th accepted press.
//
//   Processing chain: cnt -> synchroniser -> debouncer (stable level)
//                     -> two-state press FSM -> wrapping press counter -> y
//
// Ports
//   clk  in   system clock, rising edge
//   rst  in   asynchronous active-low reset (0 = reset, 1 = run)
//   cnt  in   raw button level, 1 = pressed; asynchronous and may bounce
//   y    out  registered pulse, high for one clk per TARGET accepted presses
module btn_count_fsm #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 2,
   parameter int TARGET          = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic cnt,
   output logic y
);

   localparam int CW = $clog2(TARGET + 1);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic {
      RELEASED = 1'b0,
      PRESSED  = 1'b1
   } state_t;

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   s;
   logic [DW-1:0]          db_cnt_reg;
   logic                   stable_reg;
   state_t                 state_reg;
   state_t                 state_next;
   logic                   press;
   logic [CW-1:0]          press_cnt_reg;
   logic [CW-1:0]          press_cnt_next;
   logic                   y_reg;
   logic                   y_next;

   // ---------------------------------------------------------------
   // Synchroniser: cnt enters at bit 0, s is taken from the last flop
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], cnt};
      end
   end

   assign s = sync_reg[SYNC_STAGES-1];

   // ---------------------------------------------------------------
   // Debouncer: db_cnt_reg counts clocks for which s has differed
   // from the stable level. When the DEBOUNCE_CYCLES-th differing
   // clock arrives the new level is taken and the count restarts.
   // Any return of s to the stable level clears the count, so short
   // glitches never reach the stable level.
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         db_cnt_reg <= '0;
         stable_reg <= 1'b0;
      end else if (s == stable_reg) begin
         db_cnt_reg <= '0;
      end else if (db_cnt_reg == DW'(DEBOUNCE_CYCLES - 1)) begin
         stable_reg <= s;
         db_cnt_reg <= '0;
      end else begin
         db_cnt_reg <= db_cnt_reg + DW'(1);
      end
   end

   // ---------------------------------------------------------------
   // Press FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= RELEASED;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------------------------------------------------------
   // Press FSM: next-state logic. A held button stays in PRESSED, so
   // it is only counted once; a release is needed before the next press.
   // ---------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         RELEASED: if (stable_reg)  state_next = PRESSED;
         PRESSED:  if (!stable_reg) state_next = RELEASED;
         default:                   state_next = RELEASED;
      endcase
   end

   // ---------------------------------------------------------------
   // Press FSM: outputs. An accepted press is the RELEASED -> PRESSED
   // transition. The counter wraps on the TARGET-th press and that
   // same press schedules the y pulse for the following cycle.
   // ---------------------------------------------------------------
   always_comb begin
      press          = 1'b0;
      press_cnt_next = press_cnt_reg;
      y_next         = 1'b0;
      if ((state_reg == RELEASED) && stable_reg) begin
         press = 1'b1;
      end
      if (press) begin
         if (press_cnt_reg == CW'(TARGET - 1)) begin
            press_cnt_next = '0;
            y_next         = 1'b1;
         end else begin
            press_cnt_next = press_cnt_reg + CW'(1);
         end
      end
   end

   // Counter and pulse registers; y is driven straight from a flop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         press_cnt_reg <= '0;
         y_reg         <= 1'b0;
      end else begin
         press_cnt_reg <= press_cnt_next;
         y_reg         <= y_next;
      end
   end

   assign y = y_reg;

endmodule

// File: tb/tb_btn_count_fsm.sv
// tb_btn_count_fsm
//   Self-checking bench for btn_count_fsm (default parameters).
//   Reference model: the stable level flips when the last DEBOUNCE_CYCLES
//   synchronised samples all disagree with it; every rising edge of the
//   stable level is a press, and every TARGET-th press gives y one clock later.
module tb_btn_count_fsm;

   localparam int SS  = 2;
   localparam int DC  = 2;
   localparam int TGT = 3;

   logic clk;
   logic rst;
   logic cnt;
   logic y;

   int checks   = 0;
   int failures = 0;

   btn_count_fsm #(
      .SYNC_STAGES    (SS),
      .DEBOUNCE_CYCLES(DC),
      .TARGET         (TGT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cnt(cnt),
      .y  (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   bit hist[$];    // cnt samples taken at previous edges, newest first
   bit shist[$];   // synchronised level seen before each edge, newest first
   bit m_stable;
   bit m_pend;
   int m_presses;
   bit y_exp;

   function automatic void model_reset();
      hist  = {};
      shist = {};
      for (int i = 0; i < SS; i++) hist.push_back(1'b0);
      for (int i = 0; i < DC; i++) shist.push_back(1'b0);
      m_stable  = 1'b0;
      m_pend    = 1'b0;
      m_presses = 0;
      y_exp     = 1'b0;
   endfunction

   function automatic void model_step(bit v);
      bit all_diff;
      bit prev;
      y_exp = m_pend;
      shist.push_front(hist[SS-1]);
      void'(shist.pop_back());
      all_diff = 1'b1;
      for (int i = 0; i < DC; i++)
         if (shist[i] == m_stable) all_diff = 1'b0;
      prev = m_stable;
      if (all_diff) m_stable = ~m_stable;
      m_pend = 1'b0;
      if (m_stable && !prev) begin
         m_presses++;
         m_pend = ((m_presses % TGT) == 0);
      end
      hist.push_front(v);
      void'(hist.pop_back());
   endfunction

   // ---------------- check helpers ----------------
   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
      end
   endtask

   // One clock: drive cnt, let the edge happen, compare y 1 time unit later.
   task automatic tick(input bit v, output bit yo);
      cnt = v;
      @(posedge clk);
      #1;
      if (!rst) model_reset();
      else      model_step(v);
      check("y_vs_model", int'(y), int'(y_exp));
      yo = y;
   endtask

   task automatic run_seg(input string name, input bit lvl, input int n, input int exp_pulses);
      int ones;
      bit yo;
      bit prev_y;
      ones   = 0;
      prev_y = 1'b0;
      for (int i = 0; i < n; i++) begin
         tick(lvl, yo);
         if (yo && prev_y) check("y_two_cycles", 1, 0);
         prev_y = yo;
         ones += int'(yo);
      end
      check(name, ones, exp_pulses);
      $display("seg %-10s lvl=%0d cycles=%0d y_pulses=%0d expected=%0d", name, lvl, n, ones, exp_pulses);
   endtask

   typedef struct {
      bit lvl;
      int n;
      int exp_y;
   } seg_t;

   seg_t tbl[21];
   bit   yo;

   initial begin
      // Hand-derived pulse counts for TARGET=3 starting from count 0
      tbl[0]  = '{1'b0,  4, 0};
      tbl[1]  = '{1'b1,  6, 0};   // press 1
      tbl[2]  = '{1'b0,  6, 0};
      tbl[3]  = '{1'b1,  6, 0};   // press 2
      tbl[4]  = '{1'b0,  6, 0};
      tbl[5]  = '{1'b1,  6, 1};   // press 3 -> pulse at E4
      tbl[6]  = '{1'b0,  6, 0};
      tbl[7]  = '{1'b1,  6, 0};   // press 4, no pulse
      tbl[8]  = '{1'b0,  6, 0};
      tbl[9]  = '{1'b1,  1, 0};   // bounce 1,0,1,0
      tbl[10] = '{1'b0,  1, 0};
      tbl[11] = '{1'b1,  1, 0};
      tbl[12] = '{1'b0,  1, 0};
      tbl[13] = '{1'b1,  6, 0};   // press 5
      tbl[14] = '{1'b0,  6, 0};
      tbl[15] = '{1'b1,  1, 0};   // lone glitch, ignored
      tbl[16] = '{1'b0,  6, 0};
      tbl[17] = '{1'b1, 40, 1};   // held: press 6 counted once -> pulse
      tbl[18] = '{1'b0,  6, 0};
      tbl[19] = '{1'b1,  6, 0};   // press 7
      tbl[20] = '{1'b0,  6, 0};

      model_reset();
      rst = 1'b0;
      cnt = 1'b0;
      #1;
      check("reset_y", int'(y), 0);

      // Reset held with cnt toggling: y must stay low
      for (int i = 0; i < 8; i++) tick(bit'(i % 2), yo);
      rst = 1'b1;
      run_seg("post_rst", 1'b0, 4, 0);

      // Table-driven directed segments
      for (int i = 0; i < 21; i++) run_seg("table", tbl[i].lvl, tbl[i].n, tbl[i].exp_y);

      // Randomised segments against the model
      for (int i = 0; i < 250; i++) begin
         bit lvl;
         int n;
         lvl = bit'($urandom_range(0, 1));
         n   = $urandom_range(1, 8);
         for (int k = 0; k < n; k++) tick(lvl, yo);
      end
      $display("random phase done presses_in_model=%0d", m_presses);

      // Async reset mid-count after 2 presses
      rst = 1'b0;
      tick(1'b0, yo);
      rst = 1'b1;
      run_seg("rc_gap", 1'b0, 6, 0);
      run_seg("rc_p1", 1'b1, 6, 0);
      run_seg("rc_r1", 1'b0, 6, 0);
      run_seg("rc_p2", 1'b1, 6, 0);
      run_seg("rc_r2", 1'b0, 6, 0);
      #2 rst = 1'b0;
      #1 check("async_rst_y", int'(y), 0);
      for (int i = 0; i < 3; i++) tick(bit'(i % 2), yo);
      rst = 1'b1;
      run_seg("ar_gap", 1'b0, 6, 0);
      run_seg("ar_p1", 1'b1, 6, 0);
      run_seg("ar_r1", 1'b0, 6, 0);
      run_seg("ar_p2", 1'b1, 6, 0);
      run_seg("ar_r2", 1'b0, 6, 0);
      run_seg("ar_p3_pre", 1'b1, 4, 0);   // E0..E3 of 3rd press
      tick(1'b1, yo);                     // E4
      check("third_press_E4", int'(yo), 1);
      $display("third press after reset: y at E4=%0d", yo);

      // Reset asserted between edges while y is high must clear it at once
      #2 rst = 1'b0;
      #1 check("async_clear_y", int'(y), 0);
      tick(1'b1, yo);
      rst = 1'b1;
      run_seg("final_low", 1'b0, 8, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
